// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pkg
// Purpose : Shared tag encodings and defaults for the memory port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_IF   = 2'b01,
    SRC_LD   = 2'b10
  } src_tag_e;

  localparam int DEF_ADDR_W     = 64;
  localparam int DEF_DATA_W     = 64;
  localparam int DEF_MEM_LAT    = 2;
  localparam int DEF_STARVE_MAX = 4;

  function automatic int starve_cnt_width(input int max_cnt);
    return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_if
// Purpose : Fetch, data and memory-side signals of the memory port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface mem_arb_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_flush;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_wstrb;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  if_stall;
  logic                  d_stall;

  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb, if_stall, d_stall
  );

  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb, if_stall, d_stall
  );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_resp_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module  : resp_tag_pipe
// Purpose : Tracks the owner of each in-flight read through the memory pipe.
// Revision: 1.0 - initial release
// ============================================================================
module resp_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic     clk,
  input  logic     rst,
  input  src_tag_e in_tag_i,
  input  logic     kill_if_i,
  output src_tag_e out_tag_o,
  output logic     if_pending_o,
  output logic     ld_pending_o
);

  src_tag_e tag_q [MEM_LAT];
  src_tag_e tag_d [MEM_LAT];

  // A flush kills tags already in flight; the tag entering this edge is for the new PC.
  always_comb begin
    tag_d[0] = in_tag_i;
    for (int i = 1; i < MEM_LAT; i++) begin
      tag_d[i] = (kill_if_i && tag_q[i-1] == SRC_IF) ? SRC_NONE : tag_q[i-1];
    end
  end

  always_comb begin
    if_pending_o = 1'b0;
    ld_pending_o = 1'b0;
    for (int i = 0; i < MEM_LAT - 1; i++) begin
      if (tag_q[i] == SRC_IF) if_pending_o = 1'b1;
      if (tag_q[i] == SRC_LD) ld_pending_o = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_LAT; i++) tag_q[i] <= SRC_NONE;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign out_tag_o = tag_q[MEM_LAT-1];

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Purpose : Shares one pipelined memory port between fetch and load/store.
// Revision: 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input logic      clk,
  input logic      rst,
  mem_arb_if.slave bus
);

  localparam int               CNT_W   = starve_cnt_width(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0]    starve_q, starve_d;
  logic                force_fetch, if_gnt, d_gnt, ld_gnt;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  src_tag_e            in_tag, out_tag;
  logic                if_pending, ld_pending;

  // Grants are masked by rst so every output is quiet while reset is held.
  always_comb begin
    force_fetch = (starve_q == CNT_MAX);
    d_gnt       = ~rst & bus.d_req & ~(force_fetch & bus.if_req);
    if_gnt      = ~rst & bus.if_req & ~d_gnt;
    ld_gnt      = d_gnt & ~bus.d_we;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wstrb   = '0;
    if (d_gnt) begin
      mem_addr = bus.d_addr;
      if (bus.d_we) begin
        mem_wdata = bus.d_wdata;
        mem_wstrb = bus.d_wstrb;
      end
    end else if (if_gnt) begin
      mem_addr = bus.if_addr;
    end
    in_tag = SRC_NONE;
    if (if_gnt)      in_tag = SRC_IF;
    else if (ld_gnt) in_tag = SRC_LD;
    starve_d = '0;
    if (bus.if_req & ~if_gnt) starve_d = force_fetch ? starve_q : starve_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

  resp_tag_pipe #(.MEM_LAT(MEM_LAT)) u_tag_pipe (
    .clk          (clk),
    .rst          (rst),
    .in_tag_i     (in_tag),
    .kill_if_i    (bus.if_flush),
    .out_tag_o    (out_tag),
    .if_pending_o (if_pending),
    .ld_pending_o (ld_pending)
  );

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_en    = if_gnt | d_gnt;
  assign bus.mem_we    = d_gnt & bus.d_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_wstrb = mem_wstrb;

  assign bus.if_rvalid = (out_tag == SRC_IF);
  assign bus.if_rdata  = (out_tag == SRC_IF) ? bus.mem_rdata : '0;
  assign bus.d_rvalid  = (out_tag == SRC_LD);
  assign bus.d_rdata   = (out_tag == SRC_LD) ? bus.mem_rdata : '0;

  assign bus.if_stall  = ~rst & ((bus.if_req & ~if_gnt) | if_pending | if_gnt);
  assign bus.d_stall   = ~rst & ((bus.d_req & ~d_gnt) | ld_pending | ld_gnt);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_port_arbiter
// Purpose : Directed self-checking bench for mem_port_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W  = 64;
  localparam int DATA_W  = 64;
  localparam int MEM_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  mem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input logic [63:0] a);
    return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
  endfunction

  // Pipelined memory model; non-read slots return junk so misrouting shows up.
  logic [63:0] rd_pipe [MEM_LAT];
  always @(posedge clk) begin
    for (int i = MEM_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? pat(bus.mem_addr) : 64'hDEAD_BEEF_0BAD_F00D;
  end
  assign bus.mem_rdata = rd_pipe[MEM_LAT-1];

  // Request protocol: a pending request must hold its address until granted.
  logic        p_if_pend, p_d_pend;
  logic [63:0] p_if_addr, p_d_addr;
  always @(negedge clk) begin
    if (!rst) begin
      if (p_if_pend && !bus.if_flush)
        assert (bus.if_req && bus.if_addr == p_if_addr) else $error("protocol: fetch request changed before grant");
      if (p_d_pend)
        assert (bus.d_req && bus.d_addr == p_d_addr) else $error("protocol: data request changed before grant");
    end
    p_if_pend <= !rst && bus.if_req && !bus.if_gnt;
    p_d_pend  <= !rst && bus.d_req && !bus.d_gnt;
    p_if_addr <= bus.if_addr;
    p_d_addr  <= bus.d_addr;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.if_req = 1'b1; bus.if_addr = 64'h40; bus.if_flush = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 64'h80;
    bus.d_wdata = 64'hFFFF_FFFF_FFFF_FFFF; bus.d_wstrb = 8'hFF;
    #3;
    checks++;
    if ({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.if_stall, bus.d_stall,
         bus.if_rvalid, bus.d_rvalid} !== 8'b0) begin
      $display("FAIL reset_ctrl got=%b exp=00000000", {bus.if_gnt, bus.d_gnt, bus.mem_en,
               bus.mem_we, bus.if_stall, bus.d_stall, bus.if_rvalid, bus.d_rvalid});
      failures++;
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== '0) begin
      $display("FAIL reset_membus got addr=%h wdata=%h wstrb=%h exp=0", bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
      failures++;
    end
    checks++;
    if ({bus.if_rdata, bus.d_rdata} !== '0) begin
      $display("FAIL reset_rdata got if=%h d=%h exp=0", bus.if_rdata, bus.d_rdata);
      failures++;
    end
    tick;
    bus.if_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wstrb = 8'h00;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_fetch_only;
    bus.if_req = 1'b1; bus.if_addr = 64'h100;
    #4;
    checks++;
    if ({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.if_stall} !== 5'b10101) begin
      $display("FAIL fetch_gnt got=%b exp=10101", {bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.if_stall});
      failures++;
    end
    checks++;
    if (bus.mem_addr !== 64'h100) begin
      $display("FAIL fetch_addr got=%h exp=%h", bus.mem_addr, 64'h100);
      failures++;
    end
    tick;
    bus.if_req = 1'b0;
    #4;
    checks++;
    if ({bus.if_rvalid, bus.if_stall} !== 2'b01) begin
      $display("FAIL fetch_wait got=%b exp=01", {bus.if_rvalid, bus.if_stall});
      failures++;
    end
    tick;
    #4;
    checks++;
    if ({bus.if_rvalid, bus.if_stall, bus.d_rvalid} !== 3'b100) begin
      $display("FAIL fetch_resp got=%b exp=100", {bus.if_rvalid, bus.if_stall, bus.d_rvalid});
      failures++;
    end
    checks++;
    if (bus.if_rdata !== pat(64'h100) || bus.d_rdata !== 64'h0) begin
      $display("FAIL fetch_rdata got if=%h d=%h exp if=%h d=0", bus.if_rdata, bus.d_rdata, pat(64'h100));
      failures++;
    end
    tick;
  endtask

  task automatic test_collision;
    bus.if_req = 1'b1; bus.if_addr = 64'h300;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'h2000;
    bus.d_wdata = 64'h5555_AAAA_5555_AAAA; bus.d_wstrb = 8'hFF;
    #4;
    checks++;
    if ({bus.if_gnt, bus.d_gnt, bus.mem_we, bus.if_stall, bus.d_stall} !== 5'b01011) begin
      $display("FAIL coll_gnt got=%b exp=01011", {bus.if_gnt, bus.d_gnt, bus.mem_we, bus.if_stall, bus.d_stall});
      failures++;
    end
    checks++;
    if (bus.mem_addr !== 64'h2000 || bus.mem_wstrb !== 8'h00) begin
      $display("FAIL coll_load_bus got addr=%h wstrb=%h exp addr=2000 wstrb=00", bus.mem_addr, bus.mem_wstrb);
      failures++;
    end
    tick;
    bus.d_req = 1'b0; bus.d_wstrb = 8'h00;
    #4;
    checks++;
    if ({bus.if_gnt, bus.d_gnt} !== 2'b10 || bus.mem_addr !== 64'h300) begin
      $display("FAIL coll_fetch_next got gnt=%b addr=%h exp gnt=10 addr=300", {bus.if_gnt, bus.d_gnt}, bus.mem_addr);
      failures++;
    end
    tick;
    bus.if_req = 1'b0;
    #4;
    checks++;
    if ({bus.d_rvalid, bus.d_stall, bus.if_rvalid, bus.if_stall} !== 4'b1001 || bus.d_rdata !== pat(64'h2000)) begin
      $display("FAIL coll_load_resp got flags=%b data=%h exp flags=1001 data=%h",
               {bus.d_rvalid, bus.d_stall, bus.if_rvalid, bus.if_stall}, bus.d_rdata, pat(64'h2000));
      failures++;
    end
    tick;
    #4;
    checks++;
    if ({bus.if_rvalid, bus.if_stall, bus.d_rvalid} !== 3'b100 || bus.if_rdata !== pat(64'h300)) begin
      $display("FAIL coll_fetch_resp got flags=%b data=%h exp flags=100 data=%h",
               {bus.if_rvalid, bus.if_stall, bus.d_rvalid}, bus.if_rdata, pat(64'h300));
      failures++;
    end
    tick;
  endtask

  task automatic test_starvation;
    logic [63:0] da;
    logic        exp_if;
    da = 64'h4000;
    bus.if_req = 1'b1; bus.if_addr = 64'h500;
    bus.d_req = 1'b1; bus.d_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.d_addr = da;
      if (i == 5) bus.if_req = 1'b0;
      exp_if = (i == 4);
      #4;
      checks++;
      if ({bus.if_gnt, bus.d_gnt} !== {exp_if, ~exp_if}) begin
        $display("FAIL starve_cycle%0d got=%b exp=%b", i, {bus.if_gnt, bus.d_gnt}, {exp_if, ~exp_if});
        failures++;
      end
      if (!exp_if) da = da + 64'h8;
      tick;
    end
    bus.d_req = 1'b0;
    repeat (3) tick;
  endtask

  task automatic test_back_to_back;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'hB000;
    #4;
    checks++;
    if ({bus.d_gnt, bus.d_stall} !== 2'b11) begin
      $display("FAIL b2b_first got=%b exp=11", {bus.d_gnt, bus.d_stall});
      failures++;
    end
    tick;
    bus.d_addr = 64'hB008;
    #4;
    checks++;
    if ({bus.d_gnt, bus.d_rvalid, bus.d_stall} !== 3'b101) begin
      $display("FAIL b2b_second got=%b exp=101", {bus.d_gnt, bus.d_rvalid, bus.d_stall});
      failures++;
    end
    tick;
    bus.d_req = 1'b0;
    #4;
    checks++;
    if ({bus.d_rvalid, bus.d_stall} !== 2'b11 || bus.d_rdata !== pat(64'hB000)) begin
      $display("FAIL b2b_resp0 got flags=%b data=%h exp flags=11 data=%h",
               {bus.d_rvalid, bus.d_stall}, bus.d_rdata, pat(64'hB000));
      failures++;
    end
    tick;
    #4;
    checks++;
    if ({bus.d_rvalid, bus.d_stall} !== 2'b10 || bus.d_rdata !== pat(64'hB008)) begin
      $display("FAIL b2b_resp1 got flags=%b data=%h exp flags=10 data=%h",
               {bus.d_rvalid, bus.d_stall}, bus.d_rdata, pat(64'hB008));
      failures++;
    end
    tick;
  endtask

  task automatic test_store;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 64'h6000;
    bus.d_wdata = 64'h1122_3344_5566_7788; bus.d_wstrb = 8'h0F;
    #4;
    checks++;
    if ({bus.d_gnt, bus.mem_en, bus.mem_we, bus.d_stall} !== 4'b1110) begin
      $display("FAIL store_ctrl got=%b exp=1110", {bus.d_gnt, bus.mem_en, bus.mem_we, bus.d_stall});
      failures++;
    end
    checks++;
    if (bus.mem_wstrb !== 8'h0F || bus.mem_wdata !== 64'h1122_3344_5566_7788 || bus.mem_addr !== 64'h6000) begin
      $display("FAIL store_bus got wstrb=%h wdata=%h addr=%h exp 0f 1122334455667788 6000",
               bus.mem_wstrb, bus.mem_wdata, bus.mem_addr);
      failures++;
    end
    tick;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wstrb = 8'h00;
    #4;
    checks++;
    if ({bus.d_stall, bus.d_rvalid} !== 2'b00) begin
      $display("FAIL store_after got=%b exp=00", {bus.d_stall, bus.d_rvalid});
      failures++;
    end
    tick;
    #4;
    checks++;
    if (bus.d_rvalid !== 1'b0) begin
      $display("FAIL store_no_rvalid got=%b exp=0", bus.d_rvalid);
      failures++;
    end
    tick;
  endtask

  task automatic test_flush;
    bus.if_req = 1'b1; bus.if_addr = 64'h700;
    #4;
    checks++;
    if (bus.if_gnt !== 1'b1) begin
      $display("FAIL flush_gnt0 got=%b exp=1", bus.if_gnt);
      failures++;
    end
    tick;
    bus.if_addr = 64'h800; bus.if_flush = 1'b1;
    #4;
    checks++;
    if (bus.if_gnt !== 1'b1 || bus.mem_addr !== 64'h800) begin
      $display("FAIL flush_gnt1 got gnt=%b addr=%h exp gnt=1 addr=800", bus.if_gnt, bus.mem_addr);
      failures++;
    end
    tick;
    bus.if_flush = 1'b0; bus.if_req = 1'b0;
    #4;
    checks++;
    if ({bus.if_rvalid, bus.if_stall} !== 2'b01 || bus.if_rdata !== 64'h0) begin
      $display("FAIL flush_killed got flags=%b data=%h exp flags=01 data=0",
               {bus.if_rvalid, bus.if_stall}, bus.if_rdata);
      failures++;
    end
    tick;
    #4;
    checks++;
    if ({bus.if_rvalid, bus.if_stall} !== 2'b10 || bus.if_rdata !== pat(64'h800)) begin
      $display("FAIL flush_redirect got flags=%b data=%h exp flags=10 data=%h",
               {bus.if_rvalid, bus.if_stall}, bus.if_rdata, pat(64'h800));
      failures++;
    end
    tick;
    #4;
    checks++;
    if (bus.if_rvalid !== 1'b0) begin
      $display("FAIL flush_tail got=%b exp=0", bus.if_rvalid);
      failures++;
    end
    tick;
  endtask

  task automatic test_reset_midflight;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'h9000;
    #4;
    checks++;
    if (bus.d_gnt !== 1'b1) begin
      $display("FAIL rstmf_gnt got=%b exp=1", bus.d_gnt);
      failures++;
    end
    tick;
    bus.d_req = 1'b0; bus.if_req = 1'b1; bus.if_addr = 64'hA00;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_stall, bus.d_stall, bus.d_rvalid} !== 6'b0
        || bus.mem_addr !== 64'h0) begin
      $display("FAIL rstmf_async got=%b addr=%h exp=000000 addr=0",
               {bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_stall, bus.d_stall, bus.d_rvalid}, bus.mem_addr);
      failures++;
    end
    tick;
    rst = 1'b0; bus.if_req = 1'b0;
    #4;
    checks++;
    if (bus.d_rvalid !== 1'b0 || bus.d_rdata !== 64'h0) begin
      $display("FAIL rstmf_discard got rvalid=%b data=%h exp 0 0", bus.d_rvalid, bus.d_rdata);
      failures++;
    end
    tick;
    #4;
    checks++;
    if ({bus.d_rvalid, bus.if_rvalid, bus.d_stall, bus.if_stall} !== 4'b0) begin
      $display("FAIL rstmf_quiet got=%b exp=0000", {bus.d_rvalid, bus.if_rvalid, bus.d_stall, bus.if_stall});
      failures++;
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_fetch_only;
    test_collision;
    test_starvation;
    test_back_to_back;
    test_store;
    test_flush;
    test_reset_midflight;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified instruction/data memory between the IF stage (fetch) and the MEM stage (loads/stores).
- Tracks in-flight reads through the fixed-latency memory pipeline and routes each read response back to its requester.
- Produces fetch and data stall flags consumed by the pipeline stall logic alongside the control unit's pcStall/ifidStall.
- Data accesses have priority, with a starvation guard for fetch.

Parameters:
ADDR_W, 64, byte address width
DATA_W, 64, memory word width
MEM_LAT, 2, cycles from mem_en to valid mem_rdata (legal 1..4)
STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced to win

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock, reset asynchronous and active-high
if_req  in  1  fetch request, held until if_gnt
if_addr  in  ADDR_W  fetch address
if_flush  in  1  branch/jump redirect; kills in-flight fetch responses
if_gnt  out  1  fetch accepted this cycle
if_rvalid  out  1  fetch data valid
if_rdata  out  DATA_W  fetch data
d_req  in  1  data request, held until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_wstrb  in  DATA_W/8  store byte enables
d_gnt  out  1  data access accepted this cycle
d_rvalid  out  1  load data valid
d_rdata  out  DATA_W  load data
mem_en  out  1  memory access this cycle
mem_we  out  1  memory write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wstrb  out  DATA_W/8  memory byte enables
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after a read issue
if_stall  out  1  fetch not satisfied; stall PC/IFID
d_stall  out  1  MEM stage must hold

Behaviour:
- Reset (async, immediate): tag pipe cleared, starve counter 0. All outputs 0 while rst is high; rdata outputs 0.
- Memory is fully pipelined: one issue per cycle, back-to-back issues are legal.
- Grants are combinational from the current requests and the registered starve counter:
  - force = (starve_cnt == STARVE_MAX).
  - d_gnt = d_req & ~(force & if_req).
  - if_gnt = if_req & ~d_gnt.
- Mux: mem_en = if_gnt | d_gnt. Address, write data, mem_we and mem_wstrb come from the granted source. mem_we = d_gnt & d_we; mem_wstrb = 0 unless a store is granted.
- Starve counter:
  - Increments, saturating at STARVE_MAX, on each cycle with if_req & ~if_gnt.
  - Clears on if_gnt or ~if_req.
- Tag pipe, MEM_LAT stages, 2-bit tag per stage:
  - Stage 0 loads SRC_IF on if_gnt, SRC_LD on a granted load, SRC_NONE otherwise (stores and idle).
  - Tags shift every cycle.
- Responses: the output stage tag drives the response.
  - SRC_IF → if_rvalid = 1, if_rdata = mem_rdata.
  - SRC_LD → d_rvalid = 1, d_rdata = mem_rdata.
  - Unselected rdata is held at 0.
  - Read latency is exactly MEM_LAT cycles from grant.
- Flush: if_flush rewrites every in-flight SRC_IF tag to SRC_NONE at the clock edge. The same-cycle fetch grant is for the redirected PC and survives the flush. No if_rvalid is ever produced for a killed fetch.
- Stalls:
  - if_stall = (if_req & ~if_gnt) | fetch_pending.
  - d_stall = (d_req & ~d_gnt) | load_pending.
  - *_pending = any in-flight tag of that source not yet at the output stage, or granted this cycle.
  - Each stall drops in the cycle its rvalid is asserted.
  - A granted store never stalls beyond its grant cycle.
- Simultaneous requests: data wins unless force is set. Under force, fetch wins, then the counter clears and data wins the next cycle.
- Reset mid-operation: in-flight responses are discarded; no rvalid appears after rst deasserts for any pre-reset grant.
- Request-protocol violations (address change or request drop before grant) are undefined; the bench asserts on them.

Decomposition:
- Shared package mem_arb_pkg:
  - Tag encodings: SRC_NONE = 2'b00, SRC_IF = 2'b01, SRC_LD = 2'b10.
  - Default MEM_LAT and STARVE_MAX.
- Sub-module resp_tag_pipe:
  - Parameterised MEM_LAT-deep shift register of tags.
  - Async reset and kill_if input.
  - Outputs: out_tag, if_pending, ld_pending.
- Grant/mux logic, starve counter and response routing stay in the top module.

Test Plan:
- Fetch only: if_req = 1, if_addr = 0x100, MEM_LAT = 2, no d_req → if_gnt same cycle, mem_addr = 0x100; if_rvalid at cycle +2 with mem_rdata; if_stall high for cycles 0..1.
- Collision: if_req and load d_req (d_addr = 0x2000) in the same cycle → d_gnt = 1, if_gnt = 0; fetch granted the next cycle; d_rvalid at +2, if_rvalid at +3.
- Starvation: d_req held high 10 cycles with if_req = 1 → fetch granted in exactly the 5th cycle (after 4 denials), data granted in all others.
- Store: d_we = 1, d_wstrb = 0x0F → mem_we = 1, mem_wstrb = 0x0F, no d_rvalid; d_stall low the cycle after the grant.
- Flush: fetches granted on cycles 0 and 1, if_flush on cycle 1 with if_req → the cycle-0 response is suppressed, the cycle-1 response is delivered at +2.
- Reset mid-flight: load granted, rst pulsed at +1 (async) → all outputs 0 immediately; no d_rvalid after release.
